// File: rtl/pipe_ctrl_chain_pkg.sv
// Shared types and defaults for the pipeline control chain: stage flag bundle,
// default payload/register widths and the forwarding-select width helper.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RD_W_DEF   = 5;

  typedef struct packed {
    logic valid;
    logic wen;
    logic load;
    logic halt;
  } stage_flags_t;

  // A select of 0 means "register file", k means "stage k-1", so DEPTH+1 codes.
  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_chain_if.sv
// Bundle of fetch-side handshake, per-stage controls and stage taps for the chain.
// slave is the chain's view; master is the view of the surrounding CPU core.
interface pipe_ctrl_chain_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = pipe_pkg::DATA_W_DEF,
  parameter int RD_W   = pipe_pkg::RD_W_DEF,
  parameter int SEL_W  = pipe_pkg::sel_width(DEPTH)
);

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic [RD_W-1:0]         in_rd;
  logic                    in_wen;
  logic                    in_load;
  logic                    in_halt;
  logic [DEPTH-1:0]        stage_stall;
  logic [DEPTH-1:0]        flush_mask;
  logic [RD_W-1:0]         rs1;
  logic [RD_W-1:0]         rs2;
  logic [DEPTH-1:0]        st_valid;
  logic [DEPTH*DATA_W-1:0] st_data;
  logic [DEPTH*RD_W-1:0]   st_rd;
  logic [DEPTH-1:0]        st_wen;
  logic [SEL_W-1:0]        fwd_sel_a;
  logic [SEL_W-1:0]        fwd_sel_b;
  logic                    load_use_hz;
  logic                    halted;
`ifdef PIPE_PERF_EN
  logic [31:0]             bubble_cnt;
  logic [31:0]             stall_cnt;

  modport slave (
    input  in_valid, in_data, in_rd, in_wen, in_load, in_halt,
    input  stage_stall, flush_mask, rs1, rs2,
    output in_ready, st_valid, st_data, st_rd, st_wen,
    output fwd_sel_a, fwd_sel_b, load_use_hz, halted, bubble_cnt, stall_cnt
  );

  modport master (
    output in_valid, in_data, in_rd, in_wen, in_load, in_halt,
    output stage_stall, flush_mask, rs1, rs2,
    input  in_ready, st_valid, st_data, st_rd, st_wen,
    input  fwd_sel_a, fwd_sel_b, load_use_hz, halted, bubble_cnt, stall_cnt
  );
`else
  modport slave (
    input  in_valid, in_data, in_rd, in_wen, in_load, in_halt,
    input  stage_stall, flush_mask, rs1, rs2,
    output in_ready, st_valid, st_data, st_rd, st_wen,
    output fwd_sel_a, fwd_sel_b, load_use_hz, halted
  );

  modport master (
    output in_valid, in_data, in_rd, in_wen, in_load, in_halt,
    output stage_stall, flush_mask, rs1, rs2,
    input  in_ready, st_valid, st_data, st_rd, st_wen,
    input  fwd_sel_a, fwd_sel_b, load_use_hz, halted
  );
`endif

endinterface

// File: rtl/pipe_ctrl_chain_stage_reg.sv
// One pipeline stage register; priority is flush > hold > bubble > load.
// Flush only kills the flags, payload and rd are left as they were.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_hold,
  input  logic              i_bubble,
  input  logic              i_flush,
  input  stage_flags_t      i_ld_flags,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic [RD_W-1:0]   i_ld_rd,
  output stage_flags_t      o_flags,
  output logic [DATA_W-1:0] o_data,
  output logic [RD_W-1:0]   o_rd
);

  stage_flags_t      r_flags;
  logic [DATA_W-1:0] r_data;
  logic [RD_W-1:0]   r_rd;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_flags <= '0;
      r_data  <= '0;
      r_rd    <= '0;
    end else if (i_flush) begin
      r_flags <= '0;
    end else if (!i_hold) begin
      if (i_bubble) begin
        r_flags <= '0;
        r_data  <= '0;
        r_rd    <= '0;
      end else begin
        r_flags <= i_ld_flags;
        r_data  <= i_ld_data;
        r_rd    <= i_ld_rd;
      end
    end
  end

  assign o_flags = r_flags;
  assign o_data  = r_data;
  assign o_rd    = r_rd;

endmodule

// File: rtl/pipe_ctrl_chain.sv
// DEPTH-stage Dec..WB register chain: 1 cycle/stage, stalls freeze younger stages and
// drop bubbles downstream, in_ready low while held or halted. PIPE_PERF_EN adds perf counters.
module pipe_ctrl_chain
  import pipe_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF,
  parameter int SEL_W  = sel_width(DEPTH)
) (
  input logic             clk,
  input logic             rstn,
  pipe_ctrl_chain_if.slave bus
);

  logic [DEPTH-1:0]  w_hold;
  logic [DEPTH-1:0]  w_bubble;
  logic              w_accept;
  logic              w_in_ready;
  logic              r_halted;
  logic              w_halt_set;
  logic [SEL_W-1:0]  w_sel_a;
  logic [SEL_W-1:0]  w_sel_b;

  stage_flags_t      w_flags     [DEPTH];
  logic [DATA_W-1:0] w_data      [DEPTH];
  logic [RD_W-1:0]   w_rd        [DEPTH];
  stage_flags_t      w_ld_flags  [DEPTH];
  logic [DATA_W-1:0] w_ld_data   [DEPTH];
  logic [RD_W-1:0]   w_ld_rd     [DEPTH];

  assign w_in_ready = !w_hold[0] && !r_halted;
  assign w_accept   = bus.in_valid && w_in_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    // A stall anywhere at or beyond this stage freezes it.
    assign w_hold[g] = |bus.stage_stall[DEPTH-1:g];

    if (g == 0) begin : g_head
      assign w_ld_flags[g] = '{valid: 1'b1, wen: bus.in_wen, load: bus.in_load, halt: bus.in_halt};
      assign w_ld_data[g]  = bus.in_data;
      assign w_ld_rd[g]    = bus.in_rd;
      assign w_bubble[g]   = !w_accept;
    end else begin : g_body
      assign w_ld_flags[g] = w_flags[g-1];
      assign w_ld_data[g]  = w_data[g-1];
      assign w_ld_rd[g]    = w_rd[g-1];
      assign w_bubble[g]   = w_hold[g-1];
    end

    pipe_stage_reg #(
      .DATA_W (DATA_W),
      .RD_W   (RD_W)
    ) u_stage (
      .clk        (clk),
      .rstn       (rstn),
      .i_hold     (w_hold[g]),
      .i_bubble   (w_bubble[g]),
      .i_flush    (bus.flush_mask[g]),
      .i_ld_flags (w_ld_flags[g]),
      .i_ld_data  (w_ld_data[g]),
      .i_ld_rd    (w_ld_rd[g]),
      .o_flags    (w_flags[g]),
      .o_data     (w_data[g]),
      .o_rd       (w_rd[g])
    );

    assign bus.st_valid[g]                   = w_flags[g].valid;
    assign bus.st_wen[g]                     = w_flags[g].valid && w_flags[g].wen;
    assign bus.st_data[g*DATA_W +: DATA_W]   = w_data[g];
    assign bus.st_rd[g*RD_W +: RD_W]         = w_rd[g];
  end

  // Scan oldest to youngest so the youngest (lowest-index) producer wins.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_flags[i].valid && w_flags[i].wen && (w_rd[i] == bus.rs1) && (bus.rs1 != '0))
        w_sel_a = SEL_W'(i + 1);
      if (w_flags[i].valid && w_flags[i].wen && (w_rd[i] == bus.rs2) && (bus.rs2 != '0))
        w_sel_b = SEL_W'(i + 1);
    end
  end

  assign bus.fwd_sel_a   = w_sel_a;
  assign bus.fwd_sel_b   = w_sel_b;
  assign bus.load_use_hz = w_flags[0].load &&
                           ((w_sel_a == SEL_W'(1)) || (w_sel_b == SEL_W'(1)));

  assign w_halt_set = w_flags[DEPTH-1].valid && w_flags[DEPTH-1].halt && !w_hold[DEPTH-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_halted <= 1'b0;
    end else if (w_halt_set) begin
      r_halted <= 1'b1;
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.halted   = r_halted;

`ifdef PIPE_PERF_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
    end else if (!r_halted) begin
      if (!w_flags[DEPTH-1].valid && (r_bubble_cnt != 32'hFFFF_FFFF))
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (w_hold[0] && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.bubble_cnt = r_bubble_cnt;
  assign bus.stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed bench for pipe_ctrl_chain: retirements at the oldest stage are scoreboarded,
// stage contents, forwarding, hazard and halt behaviour are checked against hand values.
module tb_pipe_ctrl_chain;
  import pipe_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int SEL_W  = sel_width(DEPTH);

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  exp_t sb_q[$];
  exp_t sb_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipe_ctrl_chain_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .RD_W(RD_W), .SEL_W(SEL_W)) bus ();

  pipe_ctrl_chain #(.DEPTH(DEPTH), .DATA_W(DATA_W), .RD_W(RD_W), .SEL_W(SEL_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] stg_data(input int k);
    return bus.st_data[k*DATA_W +: DATA_W];
  endfunction

  function automatic logic [RD_W-1:0] stg_rd(input int k);
    return bus.st_rd[k*RD_W +: RD_W];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_rd    = '0;
    bus.in_wen   = 1'b0;
    bus.in_load  = 1'b0;
    bus.in_halt  = 1'b0;
  endtask

  task automatic drive(input logic [DATA_W-1:0] d, input logic [RD_W-1:0] rd,
                       input logic wen, input logic ld, input logic hlt);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_rd    = rd;
    bus.in_wen   = wen;
    bus.in_load  = ld;
    bus.in_halt  = hlt;
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic [RD_W-1:0] rd);
    exp_t e;
    e.data = d;
    e.rd   = rd;
    sb_q.push_back(e);
  endtask

  // One accepted instruction; keep=0 for ones that are expected to be flushed.
  task automatic issue(input logic [DATA_W-1:0] d, input logic [RD_W-1:0] rd,
                       input logic wen, input logic ld, input logic hlt, input bit keep);
    drive(d, rd, wen, ld, hlt);
    chk("in_ready_at_issue", 64'(bus.in_ready), 64'd1);
    if (keep) push(d, rd);
    step();
    idle();
  endtask

  // Scoreboard monitor: the oldest stage is never stalled here, so each valid is a new retire.
  always @(negedge clk) begin
    if (rstn === 1'b1 && bus.st_valid[DEPTH-1] === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: retired data 0x%0h rd %0d, nothing expected",
                 stg_data(DEPTH-1), stg_rd(DEPTH-1));
      end else begin
        sb_e = sb_q.pop_front();
        chk("sb_retire_data", 64'(stg_data(DEPTH-1)), 64'(sb_e.data));
        chk("sb_retire_rd", 64'(stg_rd(DEPTH-1)), 64'(sb_e.rd));
      end
    end
  end

  initial begin
    rstn            = 1'b0;
    bus.stage_stall = '0;
    bus.flush_mask  = '0;
    bus.rs1         = '0;
    bus.rs2         = '0;
    idle();
    #12;
    chk("rst_valid", 64'(bus.st_valid), 64'd0);
    chk("rst_data", 64'(bus.st_data), 64'd0);
    chk("rst_rd", 64'(bus.st_rd), 64'd0);
    chk("rst_halted", 64'(bus.halted), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef PIPE_PERF_EN
    chk("rst_bubble_cnt", 64'(bus.bubble_cnt), 64'd0);
    chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    step();

    // Straight flow
    drive(32'h11, 5'd1, 1'b1, 1'b0, 1'b0); push(32'h11, 5'd1);
    step();
    chk("flow_valid_c1", 64'(bus.st_valid), 64'h1);
    chk("flow_s0_data", 64'(stg_data(0)), 64'h11);
    chk("flow_ready_c1", 64'(bus.in_ready), 64'd1);
    drive(32'h22, 5'd2, 1'b1, 1'b0, 1'b0); push(32'h22, 5'd2);
    step();
    chk("flow_valid_c2", 64'(bus.st_valid), 64'h3);
    drive(32'h33, 5'd3, 1'b1, 1'b0, 1'b0); push(32'h33, 5'd3);
    step();
    chk("flow_valid_c3", 64'(bus.st_valid), 64'h7);
    chk("flow_ready_c3", 64'(bus.in_ready), 64'd1);
    idle();
    step();
    chk("flow_valid_c4", 64'(bus.st_valid), 64'he);
    chk("flow_s3_data_c4", 64'(stg_data(3)), 64'h11);
    repeat (4) step();

    // Stall stage 1 for two cycles
    issue(32'hA0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(32'hB0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(32'hC0, 5'd4, 1'b1, 1'b0, 1'b0);
    bus.stage_stall = 4'b0010;
    #1;
    chk("stall_ready_low", 64'(bus.in_ready), 64'd0);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("stall_s0_hold", 64'(stg_data(0)), 64'hB0);
      chk("stall_s1_hold", 64'(stg_data(1)), 64'hA0);
      chk("stall_valid_lo3", 64'(bus.st_valid[2:0]), 64'h3);
      chk("stall_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.stage_stall = '0;
    #1;
    chk("stall_release_ready", 64'(bus.in_ready), 64'd1);
    push(32'hC0, 5'd4);
    step();
    idle();
    chk("resume_valid_lo3", 64'(bus.st_valid[2:0]), 64'h7);
    chk("resume_s2_data", 64'(stg_data(2)), 64'hA0);
    chk("resume_s0_data", 64'(stg_data(0)), 64'hC0);
`ifdef PIPE_PERF_EN
    chk("perf_stall_cnt", 64'(bus.stall_cnt), 64'd2);
`endif
    repeat (4) step();

    // Forwarding: stage 1 and stage 2 both write r5
    issue(32'h51, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(32'h52, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    bus.rs1 = 5'd5;
    bus.rs2 = 5'd5;
    #1;
    chk("fwd_a_youngest", 64'(bus.fwd_sel_a), 64'd2);
    chk("fwd_b_youngest", 64'(bus.fwd_sel_b), 64'd2);
    chk("fwd_no_hz", 64'(bus.load_use_hz), 64'd0);
    chk("fwd_st_wen", 64'(bus.st_wen), 64'h6);
    bus.rs1 = 5'd0;
    #1;
    chk("fwd_a_r0", 64'(bus.fwd_sel_a), 64'd0);
    bus.rs2 = 5'd0;
    repeat (4) step();

    // Load-use at stage 0
    issue(32'h70, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    bus.rs2 = 5'd7;
    #1;
    chk("lu_hz_set", 64'(bus.load_use_hz), 64'd1);
    chk("lu_sel_b", 64'(bus.fwd_sel_b), 64'd1);
    bus.rs2 = 5'd0;
    issue(32'h71, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.rs2 = 5'd7;
    bus.rs1 = 5'd7;
    #1;
    chk("lu_hz_clear", 64'(bus.load_use_hz), 64'd0);
    chk("lu_sel_b_nonload", 64'(bus.fwd_sel_b), 64'd1);
    chk("lu_sel_a_nonload", 64'(bus.fwd_sel_a), 64'd1);
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd0;
    repeat (4) step();

    // Flush stages 0 and 1 while stage 0 is loading
    issue(32'h81, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(32'h82, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(32'h83, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(32'h84, 5'd11, 1'b1, 1'b0, 1'b0);
    bus.flush_mask = 4'b0011;
    step();
    bus.flush_mask = '0;
    idle();
    chk("flush_valid", 64'(bus.st_valid), 64'hc);
    chk("flush_s2_data", 64'(stg_data(2)), 64'h82);
    chk("flush_s3_data", 64'(stg_data(3)), 64'h81);
    step();
    chk("flush_valid_next", 64'(bus.st_valid), 64'h8);
    repeat (4) step();

    // Halt marker drains to the oldest stage
    issue(32'hFF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) step();
    chk("halt_at_s3_valid", 64'(bus.st_valid[DEPTH-1]), 64'd1);
    chk("halt_not_yet", 64'(bus.halted), 64'd0);
    step();
    chk("halt_set", 64'(bus.halted), 64'd1);
    chk("halt_ready_low", 64'(bus.in_ready), 64'd0);
    drive(32'h99, 5'd12, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    idle();
    chk("halt_no_accept", 64'(bus.st_valid), 64'd0);
    chk("halt_sticky", 64'(bus.halted), 64'd1);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    // Asynchronous reset in mid-cycle
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_halted", 64'(bus.halted), 64'd0);
    chk("arst_valid", 64'(bus.st_valid), 64'd0);
    chk("arst_data", 64'(bus.st_data), 64'd0);
    chk("arst_ready", 64'(bus.in_ready), 64'd1);
`ifdef PIPE_PERF_EN
    chk("arst_bubble_cnt", 64'(bus.bubble_cnt), 64'd0);
    chk("arst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    step();
    chk("post_rst_halted", 64'(bus.halted), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
